// File: rtl/fp_div_pkg.sv
// Shared definitions for the approximate FP divider front end and the divider itself.
package fp_div_pkg;

  localparam int unsigned OP_W     = 8;
  localparam int unsigned CYC_W    = 5;
  localparam int unsigned MAX_CYC  = 7;
  localparam int unsigned NUM_KEYS = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/key_debouncer.sv
// Two-FF synchronizer plus stability counter; emits a one-cycle pulse on an accepted high->low change.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        RST_LEVEL       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // A single-bit level can only change back to the accepted value, so a mismatch run is the stable run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= RST_LEVEL;
      sync_q2 <= RST_LEVEL;
      level   <= RST_LEVEL;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_q2;
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_div_operand_sequencer.sv
// Latches divider operands from debounced board keys and sequences one reset cycle plus cyc+1 step enables.
module fp_div_operand_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MAX_CYC         = fp_div_pkg::MAX_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  input  logic [9:0] sw,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic [4:0] cyc_out,
  output logic       div_rst,
  output logic       div_step,
  output logic       busy,
  output logic       done,
  output logic       err
);

  import fp_div_pkg::*;

  state_t               state;
  logic [CYC_W-1:0]     step_cnt;
  logic [NUM_KEYS-1:0]  key_press;
  logic [NUM_KEYS-1:0]  key_level_unused;
  logic                 soft_clr;
  logic                 clr_press_unused;
  logic                 sw8_unused;
  logic                 start_illegal;
  logic                 any_load;

  assign sw8_unused = sw[8];

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST_LEVEL      (1'b1)
    ) u_key_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (key_n[i]),
      .level(key_level_unused[i]),
      .press(key_press[i])
    );
  end

  // Soft clear is a slide switch, not a bouncing key: synchronize it and accept it on the next cycle.
  key_debouncer #(
    .DEBOUNCE_CYCLES(1),
    .RST_LEVEL      (1'b0)
  ) u_clr_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (sw[9]),
    .level(soft_clr),
    .press(clr_press_unused)
  );

  assign start_illegal = (b_out == '0) || (cyc_out == '0) || (cyc_out > CYC_W'(MAX_CYC));
  assign any_load      = |key_press[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_out    <= '0;
      b_out    <= '0;
      cyc_out  <= CYC_W'(1);
      step_cnt <= '0;
      div_rst  <= 1'b0;
      div_step <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else if (soft_clr) begin
      state    <= ST_IDLE;
      a_out    <= '0;
      b_out    <= '0;
      cyc_out  <= CYC_W'(1);
      step_cnt <= '0;
      div_rst  <= 1'b0;
      div_step <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      div_rst  <= 1'b0;
      div_step <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (any_load) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
            if (key_press[0])      a_out   <= sw[7:0];
            else if (key_press[1]) b_out   <= sw[7:0];
            else                   cyc_out <= sw[4:0];
          end else if (key_press[3]) begin
            done <= 1'b0;
            if (start_illegal) begin
              state <= ST_ERR;
              err   <= 1'b1;
            end else begin
              state    <= ST_CLEAR;
              err      <= 1'b0;
              div_rst  <= 1'b1;
              busy     <= 1'b1;
              step_cnt <= '0;
            end
          end
        end
        ST_CLEAR: begin
          state    <= ST_RUN;
          div_step <= 1'b1;
        end
        // The cycle whose count equals cyc_out carries the last step pulse.
        ST_RUN: begin
          if (step_cnt == cyc_out) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            step_cnt <= step_cnt + 1'b1;
            div_step <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_operand_sequencer.sv
// Directed bench for fp_div_operand_sequencer with a short debounce window.
module tb_fp_div_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic [7:0] sw_data = 8'h00;
  logic       sw_clr = 1'b0;
  logic [9:0] sw;
  logic [7:0] a_out, b_out;
  logic [4:0] cyc_out;
  logic       div_rst, div_step, busy, done, err;

  int checks = 0;
  int failures = 0;

  int rst_pulses = 0, step_cycles = 0, step_bursts = 0, overlaps = 0, a_changes = 0;
  logic       step_prev = 1'b0;
  logic [7:0] a_prev = 8'h00;

  assign sw = {sw_clr, 1'b0, sw_data};

  always #5 clk = ~clk;

  fp_div_operand_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .MAX_CYC        (7)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_n   (key_n),
    .sw      (sw),
    .a_out   (a_out),
    .b_out   (b_out),
    .cyc_out (cyc_out),
    .div_rst (div_rst),
    .div_step(div_step),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always @(negedge clk) begin
    if (div_rst) rst_pulses <= rst_pulses + 1;
    if (div_step) step_cycles <= step_cycles + 1;
    if (div_step && !step_prev) step_bursts <= step_bursts + 1;
    if (div_rst && div_step) overlaps <= overlaps + 1;
    if (a_out !== a_prev) a_changes <= a_changes + 1;
    step_prev <= div_step;
    a_prev    <= a_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic press_key(input int k, input logic [7:0] d);
    @(negedge clk);
    sw_data  = d;
    key_n[k] = 1'b0;
    repeat (10) @(negedge clk);
    key_n[k] = 1'b1;
    repeat (14) @(negedge clk);
  endtask

  task automatic wait_busy(input string name);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  typedef struct {
    int         key;
    logic [7:0] data;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] cyc;
    int         rsts;
    int         steps;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int r0, s0, b0, c0, seen;

    vecs[0]  = '{0, 8'h96, 8'h96, 8'h00, 5'd1, 0, 0, 1'b0, 1'b0};
    vecs[1]  = '{1, 8'h05, 8'h96, 8'h05, 5'd1, 0, 0, 1'b0, 1'b0};
    vecs[2]  = '{2, 8'h03, 8'h96, 8'h05, 5'd3, 0, 0, 1'b0, 1'b0};
    vecs[3]  = '{3, 8'h00, 8'h96, 8'h05, 5'd3, 1, 4, 1'b1, 1'b0};
    vecs[4]  = '{1, 8'h00, 8'h96, 8'h00, 5'd3, 0, 0, 1'b0, 1'b0};
    vecs[5]  = '{3, 8'h00, 8'h96, 8'h00, 5'd3, 0, 0, 1'b0, 1'b1};
    vecs[6]  = '{1, 8'h05, 8'h96, 8'h05, 5'd3, 0, 0, 1'b0, 1'b0};
    vecs[7]  = '{2, 8'h08, 8'h96, 8'h05, 5'd8, 0, 0, 1'b0, 1'b0};
    vecs[8]  = '{3, 8'h00, 8'h96, 8'h05, 5'd8, 0, 0, 1'b0, 1'b1};
    vecs[9]  = '{2, 8'h01, 8'h96, 8'h05, 5'd1, 0, 0, 1'b0, 1'b0};
    vecs[10] = '{3, 8'h00, 8'h96, 8'h05, 5'd1, 1, 2, 1'b1, 1'b0};
    vecs[11] = '{2, 8'hE7, 8'h96, 8'h05, 5'd7, 0, 0, 1'b0, 1'b0};
    vecs[12] = '{3, 8'h00, 8'h96, 8'h05, 5'd7, 1, 8, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_a", 32'(a_out), 32'h0);
    check("rst_b", 32'(b_out), 32'h0);
    check("rst_cyc", 32'(cyc_out), 32'd1);
    check("rst_div_rst", 32'(div_rst), 32'd0);
    check("rst_div_step", 32'(div_step), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Loads, legal and illegal starts
    for (int i = 0; i < 13; i++) begin
      r0 = rst_pulses; s0 = step_cycles; b0 = step_bursts;
      press_key(vecs[i].key, vecs[i].data);
      check($sformatf("v%0d_a", i), 32'(a_out), 32'(vecs[i].a));
      check($sformatf("v%0d_b", i), 32'(b_out), 32'(vecs[i].b));
      check($sformatf("v%0d_cyc", i), 32'(cyc_out), 32'(vecs[i].cyc));
      check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("v%0d_rst_pulses", i), 32'(rst_pulses - r0), 32'(vecs[i].rsts));
      check($sformatf("v%0d_steps", i), 32'(step_cycles - s0), 32'(vecs[i].steps));
      check($sformatf("v%0d_step_bursts", i), 32'(step_bursts - b0), (vecs[i].steps > 0) ? 32'd1 : 32'd0);
    end

    // Bouncing key: no load during bounce, exactly one once settled
    c0 = a_changes;
    @(negedge clk);
    sw_data = 8'h42;
    for (int j = 0; j < 10; j++) begin
      key_n[0] = (j % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    check("bounce_a_held", 32'(a_out), 32'h96);
    key_n[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_a_loaded", 32'(a_out), 32'h42);
    check("bounce_one_load", 32'(a_changes - c0), 32'd1);
    key_n[0] = 1'b1;
    repeat (14) @(negedge clk);

    // Held key gives a single pulse; later sw changes are not captured
    @(negedge clk);
    sw_data = 8'h11;
    key_n[0] = 1'b0;
    repeat (8) @(negedge clk);
    sw_data = 8'h22;
    repeat (22) @(negedge clk);
    key_n[0] = 1'b1;
    repeat (14) @(negedge clk);
    check("hold_a", 32'(a_out), 32'h11);

    // Load during RUN ignored, full 8-step run
    r0 = rst_pulses; s0 = step_cycles;
    @(negedge clk);
    key_n[3] = 1'b0;
    repeat (3) @(negedge clk);
    sw_data = 8'hFF;
    key_n[0] = 1'b0;
    repeat (7) @(negedge clk);
    key_n[3] = 1'b1;
    repeat (3) @(negedge clk);
    key_n[0] = 1'b1;
    repeat (16) @(negedge clk);
    check("run_load_a", 32'(a_out), 32'h11);
    check("run_load_steps", 32'(step_cycles - s0), 32'd8);
    check("run_load_rsts", 32'(rst_pulses - r0), 32'd1);
    check("run_load_done", 32'(done), 32'd1);

    // Load and start coincide in DONE: load wins
    r0 = rst_pulses;
    @(negedge clk);
    sw_data = 8'h3C;
    key_n[0] = 1'b0;
    key_n[3] = 1'b0;
    repeat (10) @(negedge clk);
    key_n[0] = 1'b1;
    key_n[3] = 1'b1;
    repeat (14) @(negedge clk);
    check("coinc_a", 32'(a_out), 32'h3C);
    check("coinc_rsts", 32'(rst_pulses - r0), 32'd0);
    check("coinc_done", 32'(done), 32'd0);
    check("coinc_busy", 32'(busy), 32'd0);

    // Async reset at the third step
    @(negedge clk);
    key_n[3] = 1'b0;
    wait_busy("areset_start_seen");
    key_n[3] = 1'b1;
    seen = 0;
    for (int n = 0; n < 30 && seen < 3; n++) begin
      @(negedge clk);
      if (div_step) seen++;
    end
    check("areset_step3_seen", 32'(seen), 32'd3);
    #1 rst = 1'b1;
    #1;
    check("areset_a", 32'(a_out), 32'h0);
    check("areset_b", 32'(b_out), 32'h0);
    check("areset_cyc", 32'(cyc_out), 32'd1);
    check("areset_div_rst", 32'(div_rst), 32'd0);
    check("areset_div_step", 32'(div_step), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    press_key(1, 8'h05);
    press_key(2, 8'h07);
    r0 = rst_pulses; s0 = step_cycles;
    press_key(3, 8'h00);
    check("restart_steps", 32'(step_cycles - s0), 32'd8);
    check("restart_rsts", 32'(rst_pulses - r0), 32'd1);
    check("restart_done", 32'(done), 32'd1);

    // Soft clear during RUN
    @(negedge clk);
    key_n[3] = 1'b0;
    wait_busy("sclr_start_seen");
    key_n[3] = 1'b1;
    repeat (2) @(negedge clk);
    sw_clr = 1'b1;
    seen = 0;
    for (int n = 0; n < 6 && seen == 0; n++) begin
      @(negedge clk);
      if (!busy) seen = 1;
    end
    check("sclr_idle_in_time", 32'(seen), 32'd1);
    check("sclr_a", 32'(a_out), 32'h0);
    check("sclr_b", 32'(b_out), 32'h0);
    check("sclr_cyc", 32'(cyc_out), 32'd1);
    check("sclr_div_step", 32'(div_step), 32'd0);
    check("sclr_done", 32'(done), 32'd0);
    r0 = rst_pulses;
    press_key(0, 8'h55);
    press_key(1, 8'h09);
    press_key(3, 8'h00);
    check("sclr_key_a_ignored", 32'(a_out), 32'h0);
    check("sclr_key_b_ignored", 32'(b_out), 32'h0);
    check("sclr_start_ignored", 32'(rst_pulses - r0), 32'd0);
    sw_clr = 1'b0;
    repeat (10) @(negedge clk);
    check("sclr_release_a", 32'(a_out), 32'h0);
    check("sclr_release_busy", 32'(busy), 32'd0);
    check("sclr_release_err", 32'(err), 32'd0);

    check("no_rst_step_overlap", 32'(overlaps), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
